// File: rtl/sum_result_checker.sv
// Self-checking consumer for the three-operand offset adder: recomputes each
// expected result through a two-stage pipeline and keeps pass/fail statistics.
module sum_result_checker #(
   parameter int unsigned IN_W       = 19,
   parameter int unsigned OUT_W      = 20,
   parameter int unsigned OFFSET     = 102,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned EXPECT_CNT = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in1,
   input  logic [IN_W-1:0]  in2,
   input  logic [IN_W-1:0]  in3,
   input  logic [OUT_W-1:0] out1,
   output logic             match_valid,
   output logic             match,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] total_cnt,
   output logic             err_sticky,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [OUT_W-1:0] first_fail_got,
   output logic [OUT_W-1:0] first_fail_exp,
   output logic             done
);

   localparam int unsigned SUM_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 2;
   localparam int unsigned ACC_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_ready;
   logic               r_done;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic               w_ready_nxt;
   logic               w_done_nxt;
   logic               w_xfer;

   logic               r_s1_valid;
   logic [IN_W-1:0]    r_in1;
   logic [IN_W-1:0]    r_in2;
   logic [IN_W-1:0]    r_in3;
   logic [OUT_W-1:0]   r_out1;
   logic [OUT_W-1:0]   w_exp;
   logic               w_match;
   logic               w_cmp;

   logic               r_match_valid;
   logic               r_match;
   logic [CNT_W-1:0]   r_pass;
   logic [CNT_W-1:0]   r_fail;
   logic [CNT_W-1:0]   r_total;
   logic [CNT_W-1:0]   w_total_nxt;
   logic               r_err;
   logic [CNT_W-1:0]   r_ff_idx;
   logic [OUT_W-1:0]   r_ff_got;
   logic [OUT_W-1:0]   r_ff_exp;

   // clear blocks acceptance in the same cycle it is asserted
   assign in_ready = r_ready & ~clear;
   assign w_xfer   = in_valid & in_ready;
   assign w_cmp    = r_s1_valid;
   assign w_acc_nxt = r_acc + (w_xfer ? ACC_W'(1) : ACC_W'(0));

   // expected value formed at full width, then reduced modulo 2^OUT_W
   assign w_exp   = OUT_W'(SUM_W'(r_in1) + SUM_W'(r_in2) + SUM_W'(r_in3) + SUM_W'(OFFSET));
   assign w_match = (r_out1 == w_exp);
   assign w_total_nxt = (r_total == CNT_MAX) ? r_total : r_total + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) r_state <= S_IDLE;
      else                 r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_xfer) w_state_nxt = S_RUN;
         S_RUN:   if (w_cmp && (ACC_W'(w_total_nxt) == ACC_W'(EXPECT_CNT))) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_ready_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
      else                       w_ready_nxt = (w_acc_nxt < ACC_W'(EXPECT_CNT));
   end

   // pipeline, counters and first-fail capture; clear discards in-flight samples
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_ready       <= 1'b0;
         r_done        <= 1'b0;
         r_acc         <= '0;
         r_s1_valid    <= 1'b0;
         r_in1         <= '0;
         r_in2         <= '0;
         r_in3         <= '0;
         r_out1        <= '0;
         r_match_valid <= 1'b0;
         r_match       <= 1'b0;
         r_pass        <= '0;
         r_fail        <= '0;
         r_total       <= '0;
         r_err         <= 1'b0;
         r_ff_idx      <= '0;
         r_ff_got      <= '0;
         r_ff_exp      <= '0;
      end else begin
         r_ready       <= w_ready_nxt;
         r_done        <= w_done_nxt;
         r_acc         <= w_acc_nxt;
         r_s1_valid    <= w_xfer;
         r_match_valid <= w_cmp;
         if (w_xfer) begin
            r_in1  <= in1;
            r_in2  <= in2;
            r_in3  <= in3;
            r_out1 <= out1;
         end
         if (w_cmp) begin
            r_match <= w_match;
            r_total <= w_total_nxt;
            if (w_match) begin
               if (r_pass != CNT_MAX) r_pass <= r_pass + CNT_W'(1);
            end else begin
               if (r_fail != CNT_MAX) r_fail <= r_fail + CNT_W'(1);
               if (!r_err) begin
                  r_err    <= 1'b1;
                  r_ff_idx <= r_total;
                  r_ff_got <= r_out1;
                  r_ff_exp <= w_exp;
               end
            end
         end
      end
   end

   assign match_valid    = r_match_valid;
   assign match          = r_match;
   assign pass_cnt       = r_pass;
   assign fail_cnt       = r_fail;
   assign total_cnt      = r_total;
   assign err_sticky     = r_err;
   assign first_fail_idx = r_ff_idx;
   assign first_fail_got = r_ff_got;
   assign first_fail_exp = r_ff_exp;
   assign done           = r_done;

endmodule

// File: tb/tb_sum_result_checker.sv
// Directed bench for sum_result_checker: clean run to DONE, injected errors,
// width wrap, stalled stream and clear with a sample in flight.
module tb_sum_result_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] in1, in2, in3;
   logic [19:0] out1;
   logic        match_valid;
   logic        match;
   logic [15:0] pass_cnt, fail_cnt, total_cnt;
   logic        err_sticky;
   logic [15:0] first_fail_idx;
   logic [19:0] first_fail_got, first_fail_exp;
   logic        done;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;
   int mv_cnt   = 0;
   int lat_bad  = 0;
   int mv_base;
   logic last_match = 1'b0;
   int lat_q[$];

   sum_result_checker dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .in3(in3), .out1(out1),
      .match_valid(match_valid), .match(match),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .total_cnt(total_cnt),
      .err_sticky(err_sticky), .first_fail_idx(first_fail_idx),
      .first_fail_got(first_fail_got), .first_fail_exp(first_fail_exp),
      .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transfer at edge E must show match_valid right after edge E+1
   always @(negedge clk) begin
      if (match_valid) begin
         mv_cnt++;
         last_match = match;
         if (lat_q.size() == 0) lat_bad++;
         else begin
            if (lat_q[0] + 1 != cyc) lat_bad++;
            void'(lat_q.pop_front());
         end
      end
      if (!rst_n || clear) lat_q.delete();
      else if (in_valid && in_ready) lat_q.push_back(cyc + 1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errs++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] expv(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c);
      logic [21:0] s;
      s = 22'(a) + 22'(b) + 22'(c) + 22'd102;
      return s[19:0];
   endfunction

   // present one sample and hold it until accepted (bounded wait)
   task automatic xfer(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c, input logic [19:0] o);
      logic rdy;
      in1 = a; in2 = b; in3 = c; out1 = o;
      in_valid = 1'b1;
      rdy = 1'b0;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (in_ready) begin
            rdy = 1'b1;
            break;
         end
      end
      if (!rdy) chk("xfer_ready_timeout", 32'(rdy), 32'd1);
      else tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
      in1 = '0; in2 = '0; in3 = '0; out1 = '0;
      repeat (3) tick();
      chk("reset_in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_total", 32'(total_cnt), 32'd0);
      chk("reset_pass", 32'(pass_cnt), 32'd0);
      chk("reset_fail", 32'(fail_cnt), 32'd0);
      chk("reset_err", 32'(err_sticky), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_mv", 32'(match_valid), 32'd0);

      // full clean run: every triple 0..15, out1 = sum + 102
      mv_base = mv_cnt;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 16; c++)
               xfer(19'(a), 19'(b), 19'(c), 20'(a + b + c + 102));
      in_valid = 1'b0;
      repeat (3) tick();
      chk("full_pass", 32'(pass_cnt), 32'd4096);
      chk("full_fail", 32'(fail_cnt), 32'd0);
      chk("full_total", 32'(total_cnt), 32'd4096);
      chk("full_done", 32'(done), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_err", 32'(err_sticky), 32'd0);
      chk("full_mv_pulses", 32'(mv_cnt - mv_base), 32'd4096);
      chk("full_latency", 32'(lat_bad), 32'd0);

      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("done_ignores_valid", 32'(total_cnt), 32'd4096);
      chk("done_held", 32'(done), 32'd1);

      pulse_clear();
      chk("clear_done", 32'(done), 32'd0);
      chk("clear_total", 32'(total_cnt), 32'd0);
      chk("clear_pass", 32'(pass_cnt), 32'd0);
      tick();
      chk("clear_in_ready", 32'(in_ready), 32'd1);

      // injected errors at samples 37 and 50; sample n expects n + 11 + 102
      for (int n = 0; n < 60; n++)
         xfer(19'(n), 19'd11, 19'd0, (n == 37 || n == 50) ? 20'h00000 : 20'(n + 113));
      in_valid = 1'b0;
      repeat (3) tick();
      chk("inj_err", 32'(err_sticky), 32'd1);
      chk("inj_idx", 32'(first_fail_idx), 32'd37);
      chk("inj_got", 32'(first_fail_got), 32'd0);
      chk("inj_exp", 32'(first_fail_exp), 32'd150);
      chk("inj_fail", 32'(fail_cnt), 32'd2);
      chk("inj_pass", 32'(pass_cnt), 32'd58);
      chk("inj_total", 32'(total_cnt), 32'd60);

      // 3*0x7FFFF + 102 = 0x180063, so the 20-bit expected value is 0x80063
      xfer(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 20'h00064);
      in_valid = 1'b0;
      repeat (3) tick();
      chk("wrap_00064", 32'(last_match), 32'd0);
      xfer(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 20'h80063);
      in_valid = 1'b0;
      repeat (3) tick();
      chk("wrap_80063", 32'(last_match), 32'd1);
      xfer(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 20'h80064);
      in_valid = 1'b0;
      repeat (3) tick();
      chk("wrap_80064", 32'(last_match), 32'd0);
      chk("wrap_fail", 32'(fail_cnt), 32'd4);
      chk("wrap_pass", 32'(pass_cnt), 32'd59);
      chk("wrap_total", 32'(total_cnt), 32'd63);
      chk("wrap_idx_kept", 32'(first_fail_idx), 32'd37);
      chk("wrap_exp_kept", 32'(first_fail_exp), 32'd150);

      // stall and resume: valid toggles every other cycle
      pulse_clear();
      mv_base = mv_cnt;
      for (int i = 0; i < 10; i++) begin
         xfer(19'(i * 1000), 19'(i * 77), 19'(19'h40000 + 19'(i)),
              expv(19'(i * 1000), 19'(i * 77), 19'(19'h40000 + 19'(i))));
         in_valid = 1'b0;
         tick();
      end
      repeat (3) tick();
      chk("stall_total", 32'(total_cnt), 32'd10);
      chk("stall_pass", 32'(pass_cnt), 32'd10);
      chk("stall_mv_pulses", 32'(mv_cnt - mv_base), 32'd10);
      chk("stall_latency", 32'(lat_bad), 32'd0);

      // clear one cycle after the 10th transfer discards that sample
      pulse_clear();
      mv_base = mv_cnt;
      for (int i = 0; i < 10; i++)
         xfer(19'(i + 1), 19'(2 * i), 19'd3, expv(19'(i + 1), 19'(2 * i), 19'd3));
      in_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      chk("clear_forces_ready_low", 32'(in_ready), 32'd0);
      tick();
      clear = 1'b0;
      chk("midclr_total", 32'(total_cnt), 32'd0);
      chk("midclr_pass", 32'(pass_cnt), 32'd0);
      chk("midclr_fail", 32'(fail_cnt), 32'd0);
      chk("midclr_mv", 32'(match_valid), 32'd0);
      chk("midclr_done", 32'(done), 32'd0);
      for (int i = 0; i < 5; i++)
         xfer(19'(i * 3), 19'd500, 19'd7, expv(19'(i * 3), 19'd500, 19'd7));
      in_valid = 1'b0;
      repeat (3) tick();
      chk("after_clear_total", 32'(total_cnt), 32'd5);
      chk("after_clear_pass", 32'(pass_cnt), 32'd5);
      chk("after_clear_mv_pulses", 32'(mv_cnt - mv_base), 32'd14);
      chk("after_clear_latency", 32'(lat_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
